// File: rtl/ibus_pkg.sv
// Request/response structures shared by the instruction-bus initiator and responder.
package ibus_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

endpackage

// File: rtl/ibus_responder.sv
// Instruction-bus responder: serves 32-bit words from an internal image with LATENCY wait states.
//   state | meaning
//   IDLE  | ready; accepts a fetch or an image-load write
//   WAIT  | fetch accepted, counting down wait states
//   RESP  | data_ok/data/fault presented for one cycle
module ibus_responder
    import ibus_pkg::*;
#(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned MEM_WORDS  = 4096,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
    parameter logic [31:0] FAULT_DATA = 32'h0000_0013,
    localparam int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  ibus_req_t        ireq,
    output ibus_resp_t       iresp,
    output logic             fault,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] addr_q, addr_d;
    logic        addr_ok_q, addr_ok_d;
    logic        data_ok_q, data_ok_d;
    logic        fault_q, fault_d;
    logic [31:0] data_q, data_d;

    logic [31:0] mem_q [MEM_WORDS];

    logic             wr_ok;
    logic [63:0]      rd_addr;
    logic [63:0]      rd_word;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_fault;
    logic             rd_bypass;
    logic [31:0]      rd_data;

    // In IDLE the read comes straight from the bus so LATENCY==0 can answer on the accept edge;
    // a same-edge image write is forwarded so the read sees the new word.
    always_comb begin
        wr_ok     = (state_q == IDLE) && wr_en;
        rd_addr   = (state_q == IDLE) ? ireq.addr : addr_q;
        rd_word   = (rd_addr - BASE_ADDR) >> 2;
        rd_idx    = rd_word[IDX_W-1:0];
        rd_fault  = (rd_addr[1:0] != 2'b00) || (rd_addr < BASE_ADDR) ||
                    (rd_word >= 64'(MEM_WORDS));
        rd_bypass = wr_ok && (wr_idx == rd_idx);
        if (rd_fault)
            rd_data = FAULT_DATA;
        else if (rd_bypass)
            rd_data = wr_data;
        else
            rd_data = mem_q[rd_idx];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        addr_ok_d = 1'b0;
        data_ok_d = 1'b0;
        fault_d   = 1'b0;
        data_d    = data_q;
        case (state_q)
            IDLE: begin
                if (ireq.valid) begin
                    addr_d    = ireq.addr;
                    cnt_d     = 4'(LATENCY);
                    addr_ok_d = 1'b1;
                    if (LATENCY == 0) begin
                        state_d   = RESP;
                        data_ok_d = 1'b1;
                        data_d    = rd_data;
                        fault_d   = rd_fault;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = RESP;
                    data_ok_d = 1'b1;
                    data_d    = rd_data;
                    fault_d   = rd_fault;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 64'd0;
            addr_ok_q <= 1'b0;
            data_ok_q <= 1'b0;
            fault_q   <= 1'b0;
            data_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            addr_ok_q <= addr_ok_d;
            data_ok_q <= data_ok_d;
            fault_q   <= fault_d;
            data_q    <= data_d;
        end
    end

    // Image contents survive reset; loads are only taken while idle and out of reset.
    always_ff @(posedge clk) begin
        if (reset && wr_ok)
            mem_q[wr_idx] <= wr_data;
    end

    assign iresp = '{addr_ok: addr_ok_q, data_ok: data_ok_q, data: data_q};
    assign fault = fault_q;

endmodule

// File: tb/tb_ibus_responder.sv
// Bench for ibus_responder: two instances (LATENCY 2 and 0) driven in parallel against a transaction-level model.
module tb_ibus_responder;
    import ibus_pkg::*;

    localparam int          MW   = 4096;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    logic        wr_en;
    logic [11:0] wr_idx;
    logic [31:0] wr_data;

    ibus_resp_t resp_l2, resp_l0;
    logic       flt_l2, flt_l0;
    ibus_resp_t got_resp [2];
    logic       got_flt  [2];

    always #5 clk = ~clk;

    ibus_responder #(.LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(resp_l2), .fault(flt_l2),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data));

    ibus_responder #(.LATENCY(0)) u_l0 (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(resp_l0), .fault(flt_l0),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data));

    assign got_resp[0] = resp_l2;
    assign got_resp[1] = resp_l0;
    assign got_flt[0]  = flt_l2;
    assign got_flt[1]  = flt_l0;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;

    // model state, one set per instance
    int unsigned lat [2];
    logic [31:0] mmem [2][MW];
    longint      free_at [2];
    longint      resp_at [2];
    bit          pend [2];
    logic [31:0] pdata [2];
    bit          pflt [2];
    bit          e_aok [2], e_dok [2], e_flt [2];
    logic [31:0] e_data [2];

    // observation of actual responses
    logic [31:0] last_data [2];
    bit          last_flt [2];
    int          dok_cnt [2];
    int          consec [2];
    bit          prev_dok [2];

    typedef struct {
        logic [63:0] addr;
        logic [31:0] exp_data;
        bit          exp_flt;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void ref_fetch(input int d, input logic [63:0] a,
                                      output bit f, output logic [31:0] dat);
        longint unsigned off;
        f = (a % 4 != 0) || !(a >= BASE && a < BASE + 64'(4 * MW));
        off = a - BASE;
        dat = f ? 32'h0000_0013 : mmem[d][int'(off / 4)];
    endfunction

    task automatic step();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            e_aok[d] = 1'b0;
            e_dok[d] = 1'b0;
            e_flt[d] = 1'b0;
            if (!reset) begin
                free_at[d] = cyc + 1;
                pend[d]    = 1'b0;
                e_data[d]  = 32'd0;
            end else begin
                if (cyc >= free_at[d]) begin
                    if (wr_en)
                        mmem[d][wr_idx] = wr_data;
                    if (ireq.valid) begin
                        ref_fetch(d, ireq.addr, pflt[d], pdata[d]);
                        pend[d]    = 1'b1;
                        resp_at[d] = cyc + lat[d];
                        free_at[d] = cyc + lat[d] + 2;
                        e_aok[d]   = 1'b1;
                    end
                end
                if (pend[d] && resp_at[d] == cyc) begin
                    e_dok[d]  = 1'b1;
                    e_data[d] = pdata[d];
                    e_flt[d]  = pflt[d];
                    pend[d]   = 1'b0;
                end
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("cyc%0d lat%0d {addr_ok,data_ok,fault,data}", cyc, lat[d]),
                  {29'd0, got_resp[d].addr_ok, got_resp[d].data_ok, got_flt[d], got_resp[d].data},
                  {29'd0, e_aok[d], e_dok[d], e_flt[d], e_data[d]});
            if (got_resp[d].data_ok === 1'b1) begin
                dok_cnt[d]++;
                last_data[d] = got_resp[d].data;
                last_flt[d]  = got_flt[d];
                if (prev_dok[d]) consec[d]++;
            end
            prev_dok[d] = (got_resp[d].data_ok === 1'b1);
        end
        cyc++;
    endtask

    task automatic write_word(input logic [11:0] idx, input logic [31:0] dat);
        wr_en   = 1'b1;
        wr_idx  = idx;
        wr_data = dat;
        step();
        wr_en = 1'b0;
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        case ($urandom_range(0, 5))
            0, 1, 2: a = BASE + 64'(4 * $urandom_range(0, 15));
            3:       a = BASE + 64'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
            4:       a = BASE - 64'(4 * $urandom_range(1, 8));
            default: a = BASE + 64'(4 * MW) + 64'(4 * $urandom_range(0, 8));
        endcase
        return a;
    endfunction

    initial begin
        int s0, s1, c0, c1;
        lat[0] = 2;
        lat[1] = 0;
        for (int d = 0; d < 2; d++) begin
            free_at[d] = 0; resp_at[d] = 0; pend[d] = 1'b0; pdata[d] = '0; pflt[d] = 1'b0;
            e_data[d] = '0; last_data[d] = '0; last_flt[d] = 1'b0;
            dok_cnt[d] = 0; consec[d] = 0; prev_dok[d] = 1'b0;
        end
        reset   = 1'b0;
        ireq    = '0;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        step();
        step();
        reset = 1'b1;

        write_word(12'd0, 32'h0010_0093);
        write_word(12'd1, 32'hDEAD_BEEF);
        for (int i = 2; i < 16; i++) write_word(12'(i), $urandom);
        write_word(12'd4095, 32'hCAFE_F00D);

        vecs[0] = '{64'h8000_0000, 32'h0010_0093, 1'b0};
        vecs[1] = '{64'h8000_0004, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{64'h8000_0002, 32'h0000_0013, 1'b1};
        vecs[3] = '{64'h7FFF_FFFC, 32'h0000_0013, 1'b1};
        vecs[4] = '{64'h8000_4000, 32'h0000_0013, 1'b1};
        vecs[5] = '{64'h8000_3FFC, 32'hCAFE_F00D, 1'b0};
        vecs[6] = '{64'h8000_0001, 32'h0000_0013, 1'b1};
        vecs[7] = '{64'hFFFF_FFFF_8000_0000, 32'h0000_0013, 1'b1};

        for (int v = 0; v < 8; v++) begin
            s0 = dok_cnt[0];
            s1 = dok_cnt[1];
            ireq.valid = 1'b1;
            ireq.addr  = vecs[v].addr;
            step();
            ireq.valid = 1'b0;
            repeat (4) step();
            for (int d = 0; d < 2; d++) begin
                check($sformatf("vec%0d lat%0d data_ok count", v, lat[d]),
                      64'(dok_cnt[d] - (d == 0 ? s0 : s1)), 64'd1);
                check($sformatf("vec%0d lat%0d data", v, lat[d]), 64'(last_data[d]), 64'(vecs[v].exp_data));
                check($sformatf("vec%0d lat%0d fault", v, lat[d]), 64'(last_flt[d]), 64'(vecs[v].exp_flt));
            end
        end

        // valid held high: one response per LATENCY+2 cycles
        s0 = dok_cnt[0]; s1 = dok_cnt[1]; c0 = consec[0]; c1 = consec[1];
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0008;
        repeat (16) step();
        ireq.valid = 1'b0;
        check("held_valid lat2 data_ok count", 64'(dok_cnt[0] - s0), 64'd4);
        check("held_valid lat0 data_ok count", 64'(dok_cnt[1] - s1), 64'd8);
        check("held_valid back_to_back data_ok", 64'((consec[0] - c0) + (consec[1] - c1)), 64'd0);
        repeat (2) step();

        // reset while waiting abandons the fetch
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0000;
        step();
        ireq.valid = 1'b0;
        step();
        s0 = dok_cnt[0];
        reset = 1'b0;
        step();
        check("reset_mid_wait outputs",
              {29'd0, resp_l2.addr_ok, resp_l2.data_ok, flt_l2, resp_l2.data}, 64'd0);
        reset = 1'b1;
        repeat (6) step();
        check("reset_mid_wait abandoned data_ok", 64'(dok_cnt[0] - s0), 64'd0);

        // image write while busy is dropped
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0000;
        step();
        ireq.valid = 1'b0;
        write_word(12'd0, 32'h1111_1111);
        repeat (4) step();
        check("busy_write lat2 read old", 64'(last_data[0]), 64'h0010_0093);
        check("busy_write lat0 read old", 64'(last_data[1]), 64'h0010_0093);

        // write and read of the same word on one idle edge
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0000;
        write_word(12'd0, 32'h1111_1111);
        ireq.valid = 1'b0;
        repeat (4) step();
        check("same_edge lat2 read new", 64'(last_data[0]), 64'h1111_1111);
        check("same_edge lat0 read new", 64'(last_data[1]), 64'h1111_1111);

        repeat (400) begin
            reset      = ($urandom_range(0, 39) != 0);
            ireq.valid = 1'($urandom_range(0, 1));
            ireq.addr  = rand_addr();
            wr_en      = ($urandom_range(0, 2) == 0);
            wr_idx     = 12'($urandom_range(0, 15));
            wr_data    = $urandom;
            step();
        end
        reset      = 1'b1;
        ireq.valid = 1'b0;
        wr_en      = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ibus_responder.md
Name: ibus_responder

Overview:
- Responder end of the instruction bus. Accepts ibus_req_t requests from the fetch stage and returns ibus_resp_t responses.
- Serves 32-bit instructions from an internal word-addressed ROM/RAM image, with a programmable number of wait states.
- Used as the instruction-memory model in core-level simulation and as the on-chip boot ROM slave.
- Out-of-range or misaligned fetches complete normally, but return a fault flag.

Parameters:
- LATENCY, 2: wait cycles between request acceptance and data return (0..15).
- MEM_WORDS, 4096: number of 32-bit instruction words stored.
- BASE_ADDR, 64'h8000_0000: byte address of word 0.
- FAULT_DATA, 32'h0000_0013: instruction returned on a faulting fetch (NOP).

Ports:
- clk, input, 1: clock. All state updates on posedge.
- reset, input, 1: synchronous, active-low reset. reset==0 at a posedge resets the block.
- ireq, input, ibus_req_t: request. Fields used are valid and addr[63:0].
- iresp, output, ibus_resp_t: response. Fields are addr_ok, data_ok and data[31:0].
- fault, output, 1: qualifies data_ok. High means the fetch was misaligned or out of range.
- wr_en, input, 1: image-load write strobe. Honoured only in IDLE.
- wr_idx, input, $clog2(MEM_WORDS): word index for an image-load write.
- wr_data, input, 32: instruction word to write.

Behaviour:
- State machine states: IDLE, WAIT, RESP. All outputs are registered.
- Reset (reset==0 at posedge):
  - state=IDLE, counter=0, captured address=0.
  - iresp.addr_ok=0, iresp.data_ok=0, iresp.data=0, fault=0.
  - Memory contents are NOT cleared.
  - Reset mid-transaction abandons the transaction; no data_ok is ever produced for it.
- IDLE:
  - If ireq.valid at posedge T: capture ireq.addr and load counter=LATENCY.
  - During cycle T+1, iresp.addr_ok=1 for exactly one cycle.
  - Next state is RESP when LATENCY==0, otherwise WAIT.
- WAIT: counter decrements each cycle. On the posedge where counter==1, go to RESP.
- RESP:
  - iresp.data_ok=1 for exactly one cycle, with iresp.data and fault valid in that same cycle.
  - The next state is always IDLE.
  - No new request is accepted in the RESP cycle, so back-to-back requests are at least one idle cycle apart.
- Latency: data_ok is high in cycle T+1+LATENCY, relative to the acceptance posedge T.
  - LATENCY=0: addr_ok and data_ok are both high in cycle T+1.
- Address decode:
  - word index = (addr - BASE_ADDR) >> 2, using 64-bit unsigned subtraction.
  - Fault when addr[1:0]!=0, when addr < BASE_ADDR, or when index >= MEM_WORDS.
  - On a fault, data=FAULT_DATA and fault=1. Otherwise data=mem[index] and fault=0.
- Initiator protocol:
  - The fetch stage holds valid and addr stable until it sees data_ok.
  - The responder uses only the captured address. Changes to addr or valid after acceptance are ignored.
  - If valid drops mid-transaction (branch flush), the transaction still completes and data_ok still pulses. The initiator discards it.
- Simultaneous events:
  - In the RESP cycle, valid still high from the same request is not re-accepted.
  - It is re-sampled in IDLE on the next posedge. The fetch stage drops or changes the request on data_ok.
  - wr_en in a non-IDLE state is dropped, so an in-flight read never sees a partial update.
  - wr_en and ireq.valid both high in IDLE: the write completes first; the read is accepted on the same edge and returns the new value.
- Outputs outside their one-cycle windows: addr_ok=0, data_ok=0, fault=0. data holds its last value.

Test Plan:
- LATENCY=2, mem[0]=32'h0010_0093, valid with addr=64'h8000_0000 accepted at posedge T -> addr_ok=1 in T+1; data_ok=1, data=32'h0010_0093 and fault=0 in T+3; idle otherwise.
- LATENCY=0, addr=64'h8000_0004, mem[1]=32'hDEAD_BEEF -> addr_ok and data_ok both high in T+1, data=32'hDEAD_BEEF.
- Faulting fetches:
  - addr=64'h8000_0002 -> data_ok with fault=1, data=32'h0000_0013.
  - addr=64'h7FFF_FFFC -> same response.
  - addr=BASE+4*MEM_WORDS -> same response.
- valid held high continuously at addr=64'h8000_0008 -> one data_ok every LATENCY+2 cycles, i.e. period 4 for LATENCY=2; never two consecutive data_ok.
- reset=0 asserted during WAIT -> next cycle state=IDLE and all outputs 0; no data_ok appears for the abandoned request.
- Write/read interactions:
  - wr_en during WAIT with wr_idx=0, wr_data=32'h1111_1111 -> write ignored; the read returns the old mem[0].
  - wr_en in IDLE together with a read of the same index -> the read returns 32'h1111_1111.
